// File: rtl/fifo_rd_stream_adapter.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream_adapter
//
// Read-side adapter that sits directly behind a platform FIFO in its rd_clk
// domain. It issues FIFO reads and presents the returned words as a
// valid/ready stream at one word per cycle.
//
// A small skid buffer catches words that are already in flight when the
// consumer stalls. Reads are only issued when the buffer is guaranteed to
// have room for them. That guarantee comes from a credit count built purely
// from registers, so m_ready never reaches fifo_rd_en combinationally.
//
// Ports
//   clk         FIFO read clock
//   rst         synchronous, active-high reset
//   fifo_dout   FIFO read data, valid RD_LATENCY cycles after fifo_rd_en
//   fifo_empty  FIFO empty flag
//   fifo_rd_en  FIFO read enable
//   flush       synchronous discard of buffered and in-flight words
//   m_data      stream data (entry at the buffer read pointer)
//   m_valid     stream valid
//   m_ready     stream ready
//   occupancy   words currently held in the skid buffer (registered)
// ---------------------------------------------------------------------------
module fifo_rd_stream_adapter #(
  parameter int DSIZE      = 18,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = RD_LATENCY + 2,
  parameter int CSIZE      = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic             flush,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CSIZE-1:0] occupancy
);

  localparam int PSIZE = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [RD_LATENCY-1:0] inflight_q, inflight_d;
  logic [PSIZE-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PSIZE-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CSIZE-1:0]      count_q, count_d;
  logic [DSIZE-1:0]      mem_q [BUF_DEPTH];
  logic [DSIZE-1:0]      mem_d [BUF_DEPTH];

  // One extra bit so the comparison against BUF_DEPTH can never wrap.
  logic [CSIZE:0]        credit;
  logic                  discard;
  logic                  capture;
  logic                  pop;

  function automatic logic [PSIZE-1:0] ptr_inc(input logic [PSIZE-1:0] p);
    return (p == PSIZE'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reset acts as a flush that also keeps the read port quiet.
  assign discard = rst || flush;

  // Credit counts buffered words plus every read whose data has not yet
  // returned; each of those reads already owns a buffer slot.
  always_comb begin
    credit = {1'b0, count_q};
    for (int i = 0; i < RD_LATENCY; i++) begin
      credit = credit + {{CSIZE{1'b0}}, inflight_q[i]};
    end
  end

  assign fifo_rd_en = !discard && !fifo_empty && (credit < (CSIZE + 1)'(BUF_DEPTH));

  // Returning words are dropped while flushing; those FIFO words are lost.
  assign capture   = inflight_q[RD_LATENCY-1] && !discard;
  assign m_valid   = (count_q != '0) && !discard;
  assign pop       = m_valid && m_ready;
  assign m_data    = mem_q[rd_ptr_q];
  assign occupancy = count_q;

  always_comb begin
    inflight_d = '0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (discard) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Shift the read-return tracker; the oldest bit marks capture.
      inflight_d = RD_LATENCY'({inflight_q, fifo_rd_en});
      if (capture) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({capture, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (capture) begin
      mem_d[wr_ptr_q] = fifo_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Buffer contents need no reset; count_q decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // The credit limit must make a capture into a full buffer impossible.
  a_no_write_when_full : assert property (
    @(posedge clk) disable iff (rst)
    capture |-> (count_q != CSIZE'(BUF_DEPTH))
  );

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
module tb_fifo_rd_stream_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: RD_LATENCY=1, BUF_DEPTH=3
  logic        rst_a, flush_a, ready_a, rd_en_a, valid_a, clr_a;
  logic        empty_a;
  logic [17:0] dout_a, data_a;
  logic [1:0]  occ_a;
  int          rptr_a, wcnt_a;

  // Instance B: RD_LATENCY=2, BUF_DEPTH=4
  logic        rst_b, flush_b, ready_b, rd_en_b, valid_b, clr_b;
  logic        empty_b;
  logic [17:0] stage_b, dout_b, data_b;
  logic [2:0]  occ_b;
  int          rptr_b, wcnt_b;

  fifo_rd_stream_adapter #(.DSIZE(18), .RD_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst_a), .fifo_dout(dout_a), .fifo_empty(empty_a),
    .fifo_rd_en(rd_en_a), .flush(flush_a), .m_data(data_a),
    .m_valid(valid_a), .m_ready(ready_a), .occupancy(occ_a)
  );

  fifo_rd_stream_adapter #(.DSIZE(18), .RD_LATENCY(2)) dut_b (
    .clk(clk), .rst(rst_b), .fifo_dout(dout_b), .fifo_empty(empty_b),
    .fifo_rd_en(rd_en_b), .flush(flush_b), .m_data(data_b),
    .m_valid(valid_b), .m_ready(ready_b), .occupancy(occ_b)
  );

  function automatic logic [17:0] word_a(input int i);
    return 18'(i + 1);
  endfunction

  function automatic logic [17:0] word_b(input int i);
    return 18'((i * 37 + 5) ^ 32'h15A5A);
  endfunction

  // FIFO models: word i of each FIFO is word_x(i); wcnt_x words are available.
  assign empty_a = (rptr_a >= wcnt_a);
  assign empty_b = (rptr_b >= wcnt_b);

  always @(posedge clk) begin
    if (clr_a) begin
      rptr_a <= 0;
    end else if (rd_en_a) begin
      dout_a <= word_a(rptr_a);
      rptr_a <= rptr_a + 1;
    end
  end

  always @(posedge clk) begin
    if (clr_b) begin
      rptr_b <= 0;
    end else if (rd_en_b) begin
      stage_b <= word_b(rptr_b);
      rptr_b  <= rptr_b + 1;
    end
    dout_b <= stage_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first cycle after reset release, inputs settled.
  task automatic reset_a(input int words);
    rst_a   = 1'b1;
    flush_a = 1'b0;
    ready_a = 1'b1;
    clr_a   = 1'b1;
    wcnt_a  = words;
    step();
    step();
    chk("a_rst_rd_en", 32'(rd_en_a), 0);
    chk("a_rst_valid", 32'(valid_a), 0);
    chk("a_rst_occ", 32'(occ_a), 0);
    clr_a = 1'b0;
    rst_a = 1'b0;
    #1;
  endtask

  // Returns the number of clock edges until m_valid rises (bounded).
  task automatic wait_valid_a(output int lat);
    lat = 0;
    while (!valid_a && lat < 10) begin
      step();
      lat++;
    end
  endtask

  // Streams 5 words, then drops m_ready; stops in the cycle where the
  // buffer holds 0x006,0x007 and 0x008 is in flight.
  task automatic to_stall_point();
    int lat;
    reset_a(64);
    wait_valid_a(lat);
    chk("sp_first_valid_lat", 32'(lat), 2);
    for (int j = 0; j < 5; j++) begin
      chk("sp_data", {13'd0, valid_a, data_a}, {13'd0, 1'b1, word_a(j)});
      step();
    end
    ready_a = 1'b0;
    #1;
    chk("sp_rd_en_credit2", 32'(rd_en_a), 1);
    chk("sp_data_head", 32'(data_a), 32'h006);
    step();
  endtask

  initial begin
    int lat;
    int occ_max;
    int seen;
    int exp_idx;
    int cycles;

    rst_b = 1'b1; flush_b = 1'b0; ready_b = 1'b0; clr_b = 1'b1; wcnt_b = 256;

    // ---------------- streaming, RD_LATENCY=1 ----------------
    reset_a(64);
    chk("stream_rd_en_first", 32'(rd_en_a), 1);
    chk("stream_valid_first", 32'(valid_a), 0);
    wait_valid_a(lat);
    chk("stream_first_valid_lat", 32'(lat), 2);
    occ_max = 0;
    for (int i = 0; i < 64; i++) begin
      chk("stream_data", {13'd0, valid_a, data_a}, {13'd0, 1'b1, word_a(i)});
      if (int'(occ_a) > occ_max) occ_max = int'(occ_a);
      step();
    end
    chk("stream_drained_valid", 32'(valid_a), 0);
    chk("stream_drained_rd_en", 32'(rd_en_a), 0);
    chk("stream_occ_max_le2", 32'(occ_max <= 2), 1);

    // ---------------- stall at the credit limit ----------------
    to_stall_point();
    chk("stall_rd_en_off", 32'(rd_en_a), 0);
    chk("stall_occ2", 32'(occ_a), 2);
    step();
    for (int k = 0; k < 8; k++) begin
      chk("stall_hold", {13'd0, valid_a, data_a}, {13'd0, 1'b1, 18'h006});
      chk("stall_occ3", 32'(occ_a), 3);
      chk("stall_rd_en_low", 32'(rd_en_a), 0);
      step();
    end
    ready_a = 1'b1;
    #1;
    chk("stall_resume_6", {13'd0, valid_a, data_a}, {13'd0, 1'b1, 18'h006});
    chk("stall_rd_en_no_pop_dep", 32'(rd_en_a), 0);
    step();
    chk("stall_resume_7", {13'd0, valid_a, data_a}, {13'd0, 1'b1, 18'h007});
    chk("stall_rd_en_back", 32'(rd_en_a), 1);
    step();
    chk("stall_resume_8", {13'd0, valid_a, data_a}, {13'd0, 1'b1, 18'h008});
    step();
    chk("stall_resume_9", {13'd0, valid_a, data_a}, {13'd0, 1'b1, 18'h009});

    // ---------------- flush during traffic ----------------
    to_stall_point();
    flush_a = 1'b1;
    #1;
    chk("flush_valid_low", 32'(valid_a), 0);
    chk("flush_rd_en_low", 32'(rd_en_a), 0);
    step();
    flush_a = 1'b0;
    ready_a = 1'b1;
    #1;
    chk("flush_occ_cleared", 32'(occ_a), 0);
    chk("flush_valid_after", 32'(valid_a), 0);
    chk("flush_rd_en_resume", 32'(rd_en_a), 1);
    wait_valid_a(lat);
    chk("flush_next_lat", 32'(lat), 2);
    chk("flush_next_word", 32'(data_a), 32'h009);

    // ---------------- empty edge ----------------
    reset_a(1);
    chk("empty_rd_en_c0", 32'(rd_en_a), 1);
    step();
    chk("empty_rd_en_c1", 32'(rd_en_a), 0);
    chk("empty_valid_c1", 32'(valid_a), 0);
    step();
    chk("empty_word", {13'd0, valid_a, data_a}, {13'd0, 1'b1, 18'h001});
    step();
    chk("empty_valid_after_pop", 32'(valid_a), 0);
    chk("empty_occ_after_pop", 32'(occ_a), 0);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      seen += int'(rd_en_a) + int'(valid_a);
      step();
    end
    chk("empty_quiet", 32'(seen), 0);

    // ---------------- reset mid-stream ----------------
    to_stall_point();
    step();
    chk("mid_rst_occ3", 32'(occ_a), 3);
    rst_a = 1'b1;
    #1;
    chk("mid_rst_rd_en_c0", 32'(rd_en_a), 0);
    step();
    chk("mid_rst_rd_en_c1", 32'(rd_en_a), 0);
    chk("mid_rst_valid", 32'(valid_a), 0);
    chk("mid_rst_occ0", 32'(occ_a), 0);
    step();
    rst_a   = 1'b0;
    ready_a = 1'b1;
    #1;
    chk("mid_rst_rd_en_resume", 32'(rd_en_a), 1);
    chk("mid_rst_valid_low", 32'(valid_a), 0);
    wait_valid_a(lat);
    chk("mid_rst_next_lat", 32'(lat), 2);
    chk("mid_rst_next_word", 32'(data_a), 32'h009);

    // ---------------- RD_LATENCY=2, random m_ready ----------------
    rst_a = 1'b1;
    step();
    chk("b_rst_rd_en", 32'(rd_en_b), 0);
    chk("b_rst_occ", 32'(occ_b), 0);
    rst_b   = 1'b0;
    clr_b   = 1'b0;
    ready_b = 1'b1;
    #1;
    chk("b_rd_en_first", 32'(rd_en_b), 1);
    lat = 0;
    while (!valid_b && lat < 10) begin
      step();
      lat++;
    end
    chk("b_first_valid_lat", 32'(lat), 3);
    exp_idx = 0;
    occ_max = 0;
    cycles  = 0;
    while (exp_idx < 256 && cycles < 4000) begin
      ready_b = 1'($urandom_range(0, 1));
      #1;
      if (valid_b && ready_b) begin
        chk("b_data", 32'(data_b), 32'(word_b(exp_idx)));
        exp_idx++;
      end
      if (int'(occ_b) > occ_max) occ_max = int'(occ_b);
      step();
      cycles++;
    end
    chk("b_all_words", 32'(exp_idx), 256);
    chk("b_occ_max_le4", 32'(occ_max <= 4), 1);
    ready_b = 1'b1;
    step();
    step();
    chk("b_drained_valid", 32'(valid_b), 0);
    chk("b_drained_rd_en", 32'(rd_en_b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
